// File: rtl/pe_accum_bank_if.sv
// rtl/pe_accum_bank_if.sv - addend stream in, tagged result stream out, overflow status
interface pe_accum_bank_if #(
  parameter int IN_WIDTH    = 12,
  parameter int ACCUM_WIDTH = 16,
  parameter int NUM_ACCUM   = 24,
  parameter int FIFO_DEPTH  = 4
);
  localparam int SLOT_W = (NUM_ACCUM > 1) ? $clog2(NUM_ACCUM) : 1;
  localparam int FILL_W = $clog2(FIFO_DEPTH + 1);

  logic                          in_valid;
  logic                          in_ready;
  logic signed [IN_WIDTH-1:0]    in_data;
  logic                          in_first;
  logic                          in_last;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [ACCUM_WIDTH-1:0] out_data;
  logic [SLOT_W-1:0]             out_slot;
  logic [FILL_W-1:0]             fill;
  logic                          clear_ovf;
  logic                          overflow;

  modport master (
    output in_valid, in_data, in_first, in_last, out_ready, clear_ovf,
    input  in_ready, out_valid, out_data, out_slot, fill, overflow
  );

  modport slave (
    input  in_valid, in_data, in_first, in_last, out_ready, clear_ovf,
    output in_ready, out_valid, out_data, out_slot, fill, overflow
  );
endinterface

// File: rtl/pe_accum_bank.sv
// rtl/pe_accum_bank.sv - interleaved accumulator slots feeding a tagged result FIFO
module pe_accum_bank #(
  parameter int IN_WIDTH    = 12,
  parameter int ACCUM_WIDTH = 16,
  parameter int NUM_ACCUM   = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter bit SATURATE    = 1
) (
  input  logic            clock,
  input  logic            reset,
  pe_accum_bank_if.slave  bus
);
  localparam int SLOT_W = (NUM_ACCUM > 1) ? $clog2(NUM_ACCUM) : 1;
  localparam int FILL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int AW     = ACCUM_WIDTH;

  localparam logic [SLOT_W-1:0]    LAST_SLOT = SLOT_W'(NUM_ACCUM - 1);
  localparam logic [PTR_W-1:0]     LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [FILL_W:0]      DEPTH_OCC = (FILL_W + 1)'(FIFO_DEPTH);
  localparam logic signed [AW-1:0] ACC_MAX   = {1'b0, {(AW - 1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN   = {1'b1, {(AW - 1){1'b0}}};

  logic [SLOT_W-1:0]    slot;
  logic signed [AW-1:0] acc [NUM_ACCUM];

  logic                 stage_valid;
  logic signed [AW-1:0] stage_data;
  logic [SLOT_W-1:0]    stage_slot;

  logic signed [AW-1:0] fifo_data [FIFO_DEPTH];
  logic [SLOT_W-1:0]    fifo_slot [FIFO_DEPTH];
  logic [PTR_W-1:0]     wptr;
  logic [PTR_W-1:0]     rptr;
  logic [FILL_W-1:0]    count;
  logic                 ovf_q;

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [FILL_W:0]      occ;
  logic signed [AW:0]   in_ext;
  logic signed [AW:0]   acc_ext;
  logic signed [AW:0]   sum;
  logic                 sum_ovf;
  logic signed [AW-1:0] new_val;

  // Staged result counts toward occupancy so a push can never land on a full FIFO.
  always_comb begin
    occ    = {1'b0, count} + {{FILL_W{1'b0}}, stage_valid};
    accept = bus.in_valid && bus.in_ready;
    push   = stage_valid;
    pop    = bus.out_valid && bus.out_ready;
  end

  assign bus.in_ready  = (occ < DEPTH_OCC);
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = fifo_data[rptr];
  assign bus.out_slot  = fifo_slot[rptr];
  assign bus.fill      = count;
  assign bus.overflow  = ovf_q;

  // One guard bit is enough: both operands fit in AW signed bits.
  always_comb begin
    in_ext  = (AW + 1)'(bus.in_data);
    acc_ext = bus.in_first ? '0 : (AW + 1)'(acc[slot]);
    sum     = acc_ext + in_ext;
    sum_ovf = sum[AW] ^ sum[AW-1];
    new_val = sum[AW-1:0];
    if (sum_ovf && SATURATE) begin
      new_val = sum[AW] ? ACC_MIN : ACC_MAX;
    end
  end

  // Accumulator and data storage carry no reset; every slot is reloaded by in_first.
  always_ff @(posedge clock) begin
    if (accept) begin
      acc[slot] <= new_val;
    end
    if (accept && bus.in_last) begin
      stage_data <= new_val;
      stage_slot <= slot;
    end
    if (push) begin
      fifo_data[wptr] <= stage_data;
      fifo_slot[wptr] <= stage_slot;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot        <= '0;
      stage_valid <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (accept) begin
        slot <= (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
      end
      stage_valid <= accept && bus.in_last;
      if (push) begin
        wptr <= (wptr == LAST_PTR) ? '0 : wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= (rptr == LAST_PTR) ? '0 : rptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + FILL_W'(1);
        2'b01:   count <= count - FILL_W'(1);
        default: count <= count;
      endcase
      // A new overflow wins over a simultaneous clear.
      if (accept && sum_ovf) begin
        ovf_q <= 1'b1;
      end else if (bus.clear_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pe_accum_bank.sv
// tb/tb_pe_accum_bank.sv - directed checks of slot interleave, saturation, wrap and backpressure
module tb_pe_accum_bank;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   k;
  logic rdy;
  int   exp4 [4] = '{6, 8, 10, 12};

  pe_accum_bank_if #(.IN_WIDTH(12), .ACCUM_WIDTH(16), .NUM_ACCUM(4), .FIFO_DEPTH(4)) b4 ();
  pe_accum_bank_if #(.IN_WIDTH(12), .ACCUM_WIDTH(16), .NUM_ACCUM(1), .FIFO_DEPTH(4)) bs ();
  pe_accum_bank_if #(.IN_WIDTH(12), .ACCUM_WIDTH(16), .NUM_ACCUM(1), .FIFO_DEPTH(4)) bw ();

  pe_accum_bank #(.IN_WIDTH(12), .ACCUM_WIDTH(16), .NUM_ACCUM(4), .FIFO_DEPTH(4), .SATURATE(1))
    dut4 (.clock(clock), .reset(reset), .bus(b4));
  pe_accum_bank #(.IN_WIDTH(12), .ACCUM_WIDTH(16), .NUM_ACCUM(1), .FIFO_DEPTH(4), .SATURATE(1))
    dut_sat (.clock(clock), .reset(reset), .bus(bs));
  pe_accum_bank #(.IN_WIDTH(12), .ACCUM_WIDTH(16), .NUM_ACCUM(1), .FIFO_DEPTH(4), .SATURATE(0))
    dut_wrap (.clock(clock), .reset(reset), .bus(bw));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    b4.in_valid = 0; b4.in_data = '0; b4.in_first = 0; b4.in_last = 0; b4.clear_ovf = 0;
    bs.in_valid = 0; bs.in_data = '0; bs.in_first = 0; bs.in_last = 0; bs.clear_ovf = 0;
    bw.in_valid = 0; bw.in_data = '0; bw.in_first = 0; bw.in_last = 0; bw.clear_ovf = 0;
  endtask

  initial begin
    clock = 0; reset = 1; n_checks = 0; n_pass = 0;
    quiet();
    b4.out_ready = 0; bs.out_ready = 0; bw.out_ready = 0;

    // reset held two edges with random inputs
    for (int i = 0; i < 2; i++) begin
      b4.in_valid = 1'($urandom); b4.in_data = 12'($urandom);
      b4.in_first = 1'($urandom); b4.in_last = 1'($urandom);
      b4.out_ready = 1'($urandom); b4.clear_ovf = 1'($urandom);
      bs.in_valid = 1'($urandom); bs.in_data = 12'($urandom); bs.in_last = 1'($urandom);
      bw.in_valid = 1'($urandom); bw.in_data = 12'($urandom); bw.in_last = 1'($urandom);
      tick();
    end
    reset = 0;
    quiet();
    b4.out_ready = 0; bs.out_ready = 0; bw.out_ready = 0;
    check("rst_out_valid", b4.out_valid, 0);
    check("rst_fill", b4.fill, 0);
    check("rst_overflow", b4.overflow, 0);
    check("rst_in_ready", b4.in_ready, 1);
    check("rst_sat_out_valid", bs.out_valid, 0);

    // four interleaved slots: load 1..4, add 5..8 and emit
    b4.out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      b4.in_valid = 1; b4.in_data = 12'(i);
      b4.in_first = (i <= 4); b4.in_last = (i >= 5);
      tick();
      if (i == 5) check("lat_staged_not_valid", b4.out_valid, 0);
      if (i >= 6) begin
        check("interleave_valid", b4.out_valid, 1);
        check("interleave_data", b4.out_data, exp4[i-6]);
        check("interleave_slot", b4.out_slot, i - 6);
      end
    end
    quiet();
    tick();
    check("interleave_data3", b4.out_data, 12);
    check("interleave_slot3", b4.out_slot, 3);
    tick();
    check("interleave_drained", b4.out_valid, 0);

    // saturation: 17 x 2047 exceeds 32767 only on the last beat
    bs.out_ready = 1;
    for (int i = 1; i <= 17; i++) begin
      bs.in_valid = 1; bs.in_data = 12'sd2047;
      bs.in_first = (i == 1); bs.in_last = (i == 17);
      tick();
      if (i == 16) check("sat_no_ovf_yet", bs.overflow, 0);
    end
    quiet();
    check("sat_overflow", bs.overflow, 1);
    tick();
    check("sat_out_valid", bs.out_valid, 1);
    check("sat_out_data", bs.out_data, 32767);
    bs.in_valid = 1; bs.in_data = 12'sd2047; bs.clear_ovf = 1;
    tick();
    check("sat_set_beats_clear", bs.overflow, 1);
    quiet();
    bs.clear_ovf = 1;
    tick();
    quiet();
    check("sat_clear_ovf", bs.overflow, 0);

    // wrap: 16 x -2048 lands exactly on -32768, the 17th wraps to 30720
    bw.out_ready = 1;
    for (int i = 1; i <= 17; i++) begin
      bw.in_valid = 1; bw.in_data = 12'h800;
      bw.in_first = (i == 1); bw.in_last = (i == 17);
      tick();
      if (i == 16) check("wrap_min_no_ovf", bw.overflow, 0);
    end
    quiet();
    check("wrap_overflow", bw.overflow, 1);
    tick();
    check("wrap_out_data", bw.out_data, 30720);

    // backpressure on the four-slot bank
    reset = 1; tick(); reset = 0;
    b4.out_ready = 0; k = 0;
    for (int c = 0; c < 6; c++) begin
      b4.in_valid = 1; b4.in_data = 12'(100 + k);
      b4.in_first = 1; b4.in_last = 1;
      rdy = b4.in_ready;
      tick();
      if (rdy) k++;
    end
    quiet();
    check("bp_accepted", k, 4);
    check("bp_in_ready_low", b4.in_ready, 0);
    check("bp_fill_full", b4.fill, 4);
    check("bp_head_data", b4.out_data, 100);
    tick();
    check("bp_head_hold", b4.out_data, 100);
    check("bp_head_slot", b4.out_slot, 0);
    b4.out_ready = 1;
    tick();
    b4.out_ready = 0;
    check("bp_in_ready_after_pop", b4.in_ready, 1);
    check("bp_fill_after_pop", b4.fill, 3);
    check("bp_order_data1", b4.out_data, 101);
    check("bp_order_slot1", b4.out_slot, 1);
    b4.out_ready = 1;
    tick();
    check("bp_order_data2", b4.out_data, 102);
    tick();
    check("bp_order_data3", b4.out_data, 103);
    check("bp_order_slot3", b4.out_slot, 3);
    tick();
    check("bp_drained", b4.out_valid, 0);

    // reset with three results queued
    b4.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      b4.in_valid = 1; b4.in_data = 12'(7 + i); b4.in_first = 1; b4.in_last = 1;
      tick();
    end
    quiet();
    tick();
    check("mid_fill_3", b4.fill, 3);
    reset = 1; tick(); reset = 0;
    check("mid_rst_fill", b4.fill, 0);
    check("mid_rst_out_valid", b4.out_valid, 0);
    check("mid_rst_in_ready", b4.in_ready, 1);
    b4.in_valid = 1; b4.in_data = 12'sd55; b4.in_first = 1; b4.in_last = 1; b4.out_ready = 1;
    tick();
    quiet();
    check("mid_staged_not_valid", b4.out_valid, 0);
    tick();
    check("mid_next_valid", b4.out_valid, 1);
    check("mid_next_data", b4.out_data, 55);
    check("mid_next_slot", b4.out_slot, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pe_accum_bank.md
PE_ACCUM_BANK -- requirements
Module: pe_accum_bank

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 12, signed dot-product input width.
REQ-002 SHALL have parameter ACCUM_WIDTH, default 16, signed accumulator width; ACCUM_WIDTH >= IN_WIDTH.
REQ-003 SHALL have parameter NUM_ACCUM, default 24, number of interleaved accumulator slots; NUM_ACCUM >= 1.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output FIFO depth; FIFO_DEPTH >= 2.
REQ-005 SHALL have parameter SATURATE, default 1; 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-006 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1, input beat present.
REQ-009 SHALL have port in_ready, output, 1, input beat accepted when in_valid and in_ready are both high.
REQ-010 SHALL have port in_data, input, IN_WIDTH, signed addend.
REQ-011 SHALL have port in_first, input, 1, load slot instead of add.
REQ-012 SHALL have port in_last, input, 1, emit slot result after this beat.
REQ-013 SHALL have port out_valid, output, 1, FIFO head valid.
REQ-014 SHALL have port out_ready, input, 1, consumer pop.
REQ-015 SHALL have port out_data, output, ACCUM_WIDTH, signed result.
REQ-016 SHALL have port out_slot, output, clog2(NUM_ACCUM) (min 1), slot index of result.
REQ-017 SHALL have port fill, output, clog2(FIFO_DEPTH+1), FIFO occupancy.
REQ-018 SHALL have port clear_ovf, input, 1, clears sticky overflow.
REQ-019 SHALL have port overflow, output, 1, sticky overflow flag.

Function
REQ-020 Slot pointer SHALL start at 0, advance by 1 per accepted beat, and wrap from NUM_ACCUM-1 to 0; non-accepted cycles leave it unchanged.
REQ-021 Accepted beat SHALL compute new = sext(in_data) if in_first, else acc[slot] + sext(in_data), and write it to acc[slot] at the same edge.
REQ-022 Sum SHALL be computed at ACCUM_WIDTH+1 bits; out-of-range result SHALL clamp to 2^(ACCUM_WIDTH-1)-1 or -2^(ACCUM_WIDTH-1) if SATURATE=1, else keep the low ACCUM_WIDTH bits.
REQ-023 Any out-of-range sum SHALL set overflow at the next edge in both modes; overflow SHALL clear only on reset or clear_ovf; simultaneous set and clear_ovf SHALL leave it set.
REQ-024 Beat with in_first and in_last both high SHALL emit sext(in_data) (single-term accumulation).
REQ-025 Accepted beat with in_last SHALL load {new, slot} into a one-entry stage register at edge N and push it into the FIFO at edge N+1; out_valid SHALL be high from edge N+1 if the FIFO was empty (latency 2 edges in to out).
REQ-026 FIFO SHALL be first-word-fall-through, in order; pop occurs when out_valid and out_ready are high; out_data/out_slot SHALL hold while out_valid is high and out_ready is low.
REQ-027 in_ready SHALL be high iff fill + stage_valid < FIFO_DEPTH, registered-free combinational from state only; it SHALL NOT depend on out_ready or in_valid.
REQ-028 Simultaneous push and pop SHALL leave fill unchanged; pop on empty and push on full SHALL never occur.
REQ-029 Beats without in_last SHALL never touch the FIFO; in_ready low SHALL stall accumulation and the slot pointer.

Reset
REQ-030 While reset is high at an edge: slot pointer, stage valid, FIFO pointers, fill, overflow SHALL become 0; out_valid 0; in_ready SHALL be 1 from the following cycle.
REQ-031 Accumulator contents SHALL be don't-care after reset; first beat to each slot after reset carries in_first.
REQ-032 Reset mid-operation SHALL discard staged and queued results and restart at slot 0.

Verification (IN_WIDTH=12, ACCUM_WIDTH=16, FIFO_DEPTH=4)
REQ-033 Reset: assert reset 2 cycles with random inputs -> out_valid=0, fill=0, overflow=0, in_ready=1 next cycle.
REQ-034 NUM_ACCUM=4: beats 1..8, in_first on beats 1-4, in_last on 5-8, out_ready=1 -> outputs (6,slot0),(8,1),(10,2),(12,3), first out_valid 2 edges after beat 5.
REQ-035 NUM_ACCUM=1, SATURATE=1: 17 beats of 2047 (first, last on 17th) -> out_data=32767, overflow=1; clear_ovf -> overflow=0.
REQ-036 NUM_ACCUM=1, SATURATE=0: 17 beats of -2048 -> out_data=30720 (wrapped -34816), overflow=1.
REQ-037 Backpressure: out_ready=0, stream single-term beats (first+last) -> in_ready low once fill+stage=4, fill=4; one pop -> in_ready high next cycle, order preserved.
REQ-038 Reset mid-stream with 3 results queued -> fill=0, out_valid=0, next result tagged slot 0.
